// File: rtl/cpuori_div_if.sv
// Start/done handshake and operand/result bus between the A-stage and the
// iterative divider cell.
interface cpuori_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             A_div_start;
  logic             A_div_signed;
  logic [WIDTH-1:0] A_div_src1;
  logic [WIDTH-1:0] A_div_src2;
  logic             A_div_busy;
  logic             A_div_done;
  logic [WIDTH-1:0] A_div_quotient;
  logic [WIDTH-1:0] A_div_remainder;

  modport master (
    output A_div_start,
    output A_div_signed,
    output A_div_src1,
    output A_div_src2,
    input  A_div_busy,
    input  A_div_done,
    input  A_div_quotient,
    input  A_div_remainder
  );

  modport slave (
    input  A_div_start,
    input  A_div_signed,
    input  A_div_src1,
    input  A_div_src2,
    output A_div_busy,
    output A_div_done,
    output A_div_quotient,
    output A_div_remainder
  );
endinterface

// File: rtl/cpuori_div_cell.sv
// Iterative restoring divider for div/divu: one quotient bit per cycle,
// fixed WIDTH+3 cycle latency from start to done, all outputs registered.
module cpuori_div_cell #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  cpuori_div_if.slave  div
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   src1_q, src1_d;
  logic [WIDTH-1:0]   src2_q, src2_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dq_q, dq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   remo_q, remo_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_sh;
  logic               neg1, neg2;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    sgn_d   = sgn_q;
    dvsr_d  = dvsr_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    done_d  = 1'b0;

    // Partial remainder after the shift, and the trial subtraction with a
    // borrow bit so a negative result is visible in trial[WIDTH].
    rem_sh = {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
    trial  = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvsr_q};
    neg1   = sgn_q & src1_q[WIDTH-1];
    neg2   = sgn_q & src2_q[WIDTH-1];

    unique case (state_q)
      IDLE: begin
        if (div.A_div_start) begin
          src1_d  = div.A_div_src1;
          src2_d  = div.A_div_src2;
          sgn_d   = div.A_div_signed;
          state_d = PREP;
        end
      end
      PREP: begin
        // Magnitude of the most negative value is itself, read as unsigned
        dq_d    = neg1 ? -src1_q : src1_q;
        dvsr_d  = neg2 ? -src2_q : src2_q;
        q_neg_d = neg1 ^ neg2;
        r_neg_d = neg1;
        zero_d  = (src2_q == '0);
        rem_d   = '0;
        cnt_d   = CNT_W'(WIDTH - 1);
        state_d = ITER;
      end
      ITER: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dq_d  = {dq_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          dq_d  = {dq_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        // Truncating division: remainder follows the dividend's sign
        if (zero_q) begin
          quo_d  = '1;
          remo_d = src1_q;
        end else begin
          quo_d  = q_neg_q ? -dq_q : dq_q;
          remo_d = r_neg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src1_q  <= '0;
      src2_q  <= '0;
      sgn_q   <= 1'b0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      sgn_q   <= sgn_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
    end
  end

  assign div.A_div_busy      = busy_q;
  assign div.A_div_done      = done_q;
  assign div.A_div_quotient  = quo_q;
  assign div.A_div_remainder = remo_q;

endmodule

// File: tb/tb_cpuori_div_cell.sv
// Self-checking bench for cpuori_div_cell: directed vector table, multi-cycle
// corner sequences and random operations against an arithmetic model.
module tb_cpuori_div_cell;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 3;

  typedef struct {
    string        name;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  cpuori_div_if #(.WIDTH(W)) bus ();

  cpuori_div_cell #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .div   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: truncating division done in 64-bit signed arithmetic
  function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drives start in the current cycle, then walks to the done cycle. Extra
  // start pulses at cycles p1/p2 must be ignored by the busy cell.
  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int p1, input int p2);
    bus.A_div_start  = 1'b1;
    bus.A_div_signed = sgn;
    bus.A_div_src1   = a;
    bus.A_div_src2   = b;
    @(posedge clk); #1;
    for (int k = 1; k < LAT; k++) begin
      bus.A_div_start  = (k == p1 || k == p2);
      bus.A_div_signed = 1'($urandom);
      bus.A_div_src1   = $urandom;
      bus.A_div_src2   = $urandom;
      check({name, "_inflight"}, {62'd0, bus.A_div_busy, bus.A_div_done}, 64'd2);
      check({name, "_held"}, {bus.A_div_quotient, bus.A_div_remainder}, {prev_q, prev_r});
      @(posedge clk); #1;
    end
    bus.A_div_start = 1'b0;
    check({name, "_done"}, {62'd0, bus.A_div_busy, bus.A_div_done}, 64'd1);
    check({name, "_quot"}, 64'(bus.A_div_quotient), 64'(eq));
    check({name, "_rem"}, 64'(bus.A_div_remainder), 64'(er));
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic idle_check(input string name);
    @(posedge clk); #1;
    check({name, "_idle"}, {62'd0, bus.A_div_busy, bus.A_div_done}, 64'd0);
    check({name, "_stable"}, {bus.A_div_quotient, bus.A_div_remainder}, {prev_q, prev_r});
  endtask

  vec_t         vecs[9];
  logic [W-1:0] mq, mr, ra, rb;
  logic         rs;

  initial begin
    vecs[0] = '{"u100_7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{"s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{"u_fff9_2",   1'b0, 32'hFFFF_FFF9,  32'h0000_0002,  32'h7FFF_FFFC,  32'h0000_0001};
    vecs[3] = '{"s_divzero",  1'b1, 32'h8000_0005,  32'h0000_0000,  32'hFFFF_FFFF,  32'h8000_0005};
    vecs[4] = '{"s_overflow", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0000};
    vecs[5] = '{"u_ffff_16",  1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF,  32'h0000_000F};
    vecs[6] = '{"s_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0000_0001};
    vecs[7] = '{"u_divzero",  1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[8] = '{"s_m9_m3",    1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFD,  32'd3,          32'd0};

    reset            = 1'b1;
    bus.A_div_start  = 1'b0;
    bus.A_div_signed = 1'b0;
    bus.A_div_src1   = '0;
    bus.A_div_src2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {62'd0, bus.A_div_busy, bus.A_div_done}, 64'd0);
    check("reset_results", {bus.A_div_quotient, bus.A_div_remainder}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 0, 0);
      idle_check(vecs[i].name);
    end

    // Start pulses while busy are dropped, not queued
    run_op("ignore_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 5, 20);
    idle_check("ignore_start");
    idle_check("ignore_start2");

    // Second start issued in the first operation's done cycle
    run_op("b2b_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
    run_op("b2b_second", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0, 0);
    idle_check("b2b");

    // Reset in cycle 17 of an operation, restart at cycle 20
    bus.A_div_start  = 1'b1;
    bus.A_div_signed = 1'b0;
    bus.A_div_src1   = 32'd100;
    bus.A_div_src2   = 32'd7;
    @(posedge clk); #1;
    bus.A_div_start = 1'b0;
    for (int k = 1; k < 17; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_flags", {62'd0, bus.A_div_busy, bus.A_div_done}, 64'd0);
    check("midreset_results", {bus.A_div_quotient, bus.A_div_remainder}, 64'd0);
    prev_q = '0;
    prev_r = '0;
    idle_check("midreset_c19");
    @(posedge clk); #1;
    run_op("after_reset_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0);
    idle_check("after_reset");

    // Random operations, occasionally chained back-to-back
    for (int n = 0; n < 24; n++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = '0;
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: begin ra = 32'h8000_0000; rb = '1; end
      endcase
      model(rs, ra, rb, mq, mr);
      run_op("rand", rs, ra, rb, mq, mr, 0, 0);
      if ($urandom_range(0, 2) != 0) idle_check("rand");
    end
    idle_check("rand_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpuori_div_cell.md
# cpuori_div_cell

Iterative 32-bit integer divider for the cpuori Nios II core. It is the inverse companion of the multiplier cell and the A-stage execute unit that serves div/divu, with a start/done handshake toward the stall logic. Signed or unsigned operands are selected per operation. The cell computes one quotient bit per cycle and returns the quotient and remainder together after a fixed latency.

## Interface
- WIDTH, 32, operand/result width; must be even and ≥ 4; latency scales as WIDTH+3
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- A_div_start  in  1  request; sampled only in IDLE
- A_div_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- A_div_src1  in  WIDTH  dividend; captured with start
- A_div_src2  in  WIDTH  divisor; captured with start
- A_div_busy  out  1  high while an operation is in flight (state ≠ IDLE)
- A_div_done  out  1  one-cycle pulse; results valid this cycle and held until next done
- A_div_quotient  out  WIDTH  quotient
- A_div_remainder  out  WIDTH  remainder

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE: on start=1, capture operands and the signed flag, then go to PREP. Start is ignored in every other state (no queueing).
- PREP:
  - If signed, convert each operand to its magnitude and record q_neg = sign1^sign2 and r_neg = sign1.
  - Record div_zero = (src2==0).
  - Clear the partial remainder, load the shift register with |dividend|, set bit counter = WIDTH-1, go to ITER.
- ITER (restoring):
  - Shift {rem, dq} left by 1.
  - trial = rem_shifted − |divisor|, computed at WIDTH+1 bits.
  - If trial ≥ 0, rem = trial[WIDTH-1:0] and the shifted-in quotient bit = 1; else keep rem and shift in 0.
  - When counter==0 go to FIX; otherwise decrement the counter.
- FIX:
  - Apply signs: quotient negated if q_neg, remainder negated if r_neg (truncating division; the remainder takes the dividend's sign).
  - Divide by zero overrides: quotient = all ones, remainder = original src1 (raw, sign unchanged).
  - Register the results, pulse done, go to IDLE.
- Signed overflow (−2^(WIDTH-1) / −1) needs no special case. It yields quotient 0x80000000 and remainder 0 for WIDTH=32.
- Divide by zero takes the full latency; there is no early exit, so the latency is always deterministic.
- Reset values: busy=0, done=0, quotient=0, remainder=0, state=IDLE.
- Reset mid-operation: abort, return to IDLE, no done pulse, results cleared to 0.

## Timing
- Start sampled high at edge E0 → PREP at E1 → WIDTH ITER edges (E2..E(WIDTH+1)) → FIX at E(WIDTH+2).
- Done and results appear in the cycle after E(WIDTH+2). That is 35 cycles after the start cycle for WIDTH=32.
- Busy rises the cycle after start is sampled and falls in the done cycle (done=1, busy=0 together).
- A start asserted during the done cycle is accepted, so back-to-back operations run with no bubble beyond the fixed latency.
- Quotient and remainder change only on the done edge or on reset; they are stable between done pulses.
- Inputs src1, src2 and signed may change freely after the start cycle.
- No combinational input→output paths. All outputs are registered.

## Test plan
- Unsigned 100/7, start at cycle 0 → done only in cycle 35: quotient=14, remainder=2; busy high in cycles 1–34.
- Signed −7/2 (0xFFFFFFF9, 0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Unsigned 0xFFFFFFF9/2 → quotient=0x7FFFFFFC, remainder=1.
- Divide by zero, signed 0x80000005/0 → quotient=0xFFFFFFFF, remainder=0x80000005, latency still 35. Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Pulse start again at cycles 5 and 20 during a busy operation → ignored; exactly one done pulse, and results match the first operands.
- Reset at cycle 17 mid-operation → busy=0 and outputs 0 next cycle, no done pulse. A start at cycle 20 of 9/3 → done at cycle 55 with quotient=3, remainder=0.
- Back-to-back: start in the first operation's done cycle (0xFFFFFFFF/0x10 unsigned) → second done 35 cycles later: quotient=0x0FFFFFFF, remainder=0xF.
